// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: a byte FIFO fed over the system bus, drained one byte per clock into a
// parametrised CRC register. The FSM, FIFO pointers and bus read data are registered in one block.
module crc_stream_engine #(
  parameter int unsigned CRC_W       = 32,
  parameter logic [31:0] POLY        = 32'h814141AB,
  parameter logic [31:0] INIT        = 32'h0,
  parameter logic [31:0] XOR_OUT     = 32'h0,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0,
  parameter int unsigned DEPTH       = 256,
  parameter logic [16:0] BASE_ADDR   = 17'h680
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CRC_W-1:0] PolyW  = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] InitW  = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XorW   = XOR_OUT[CRC_W-1:0];
  localparam logic [AW:0]      FullCnt = (AW+1)'(DEPTH);

  localparam logic [16:0] AddrData   = BASE_ADDR;
  localparam logic [16:0] AddrStatus = BASE_ADDR + 17'h08;
  localparam logic [16:0] AddrResult = BASE_ADDR + 17'h10;
  localparam logic [16:0] AddrCtrl   = BASE_ADDR + 17'h18;
  localparam logic [16:0] AddrCount  = BASE_ADDR + 17'h20;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r;
  endfunction

  // Byte enters the top of the register, then eight MSB-first division steps.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] b);
    logic [CRC_W-1:0] r;
    r = c ^ (CRC_W'(b) << (CRC_W - 8));
    for (int i = 0; i < 8; i++) r = r[CRC_W-1] ? ((r << 1) ^ PolyW) : (r << 1);
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             irq_en_q, irq_en_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ctrl_pend_q;
  logic [3:0]       ctrl_bits_q;
  logic [31:0]      sdata_out_q, sdata_out_d;
  logic             busy_q, irq_q;
  logic [7:0]       mem_q [DEPTH];

  logic       wr_data, wr_ctrl, push, pop, clr, start, full, empty;
  logic [7:0] byte_in;
  logic [31:0] rdata;
  logic        unused_sdata;

  assign unused_sdata = ^sdata_in[31:8];
  assign wr_data = swr && (saddress == AddrData);
  assign wr_ctrl = swr && (saddress == AddrCtrl);
  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign byte_in = REFLECT_IN ? rev8(mem_q[rptr_q]) : mem_q[rptr_q];
  // CTRL writes are captured on the write edge and acted upon one edge later.
  assign clr     = ctrl_pend_q & ctrl_bits_q[1];
  assign start   = ctrl_pend_q & ctrl_bits_q[0];

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    result_d = result_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    pop      = 1'b0;
    if (ctrl_pend_q) begin
      irq_en_d = ctrl_bits_q[2];
      if (ctrl_bits_q[3]) done_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          crc_d   = InitW;
          done_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!empty) begin
          pop   = 1'b1;
          crc_d = crc_byte(crc_q, byte_in);
        end else begin
          result_d = (REFLECT_OUT ? rev_crc(crc_q) : crc_q) ^ XorW;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    push = wr_data & (!full | pop);
    if (wr_data && !push) ovf_d = 1'b1;
    if (clr) begin
      state_d  = StIdle;
      crc_d    = InitW;
      result_d = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      pop      = 1'b0;
      push     = 1'b0;
    end
    wptr_d  = clr ? '0 : wptr_q + AW'(push);
    rptr_d  = clr ? '0 : rptr_q + AW'(pop);
    count_d = clr ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    rdata = '0;
    case (saddress)
      AddrStatus: rdata = {26'd0, irq_en_q, ovf_q, done_q, (state_q == StRun), empty, full};
      AddrResult: rdata = 32'(result_q);
      AddrCount:  rdata = 32'(count_q);
      default:    rdata = '0;
    endcase
    sdata_out_d = srd ? rdata : sdata_out_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      crc_q       <= InitW;
      result_q    <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ctrl_pend_q <= 1'b0;
      ctrl_bits_q <= '0;
      sdata_out_q <= '0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      result_q    <= result_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      irq_en_q    <= irq_en_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ctrl_pend_q <= wr_ctrl;
      ctrl_bits_q <= wr_ctrl ? sdata_in[3:0] : ctrl_bits_q;
      sdata_out_q <= sdata_out_d;
      busy_q      <= (state_d == StRun);
      irq_q       <= done_d & irq_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= sdata_in[7:0];
  end

  assign sdata_out = sdata_out_q;
  assign busy      = busy_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: four parameter sets driven over a shared bus, results checked
// against a bit-serial polynomial-division model of each configured CRC.
module tb_crc_stream_engine;

  localparam logic [16:0] Base      = 17'h680;
  localparam logic [16:0] OffData   = 17'h00;
  localparam logic [16:0] OffStatus = 17'h08;
  localparam logic [16:0] OffResult = 17'h10;
  localparam logic [16:0] OffCtrl   = 17'h18;
  localparam logic [16:0] OffCount  = 17'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] saddress;
  logic [31:0] sdata_in;
  logic [3:0]  srd_v, swr_v, busy_v, irq_v;
  logic [31:0] dout [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc_stream_engine u_def (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd_v[0]), .swr(swr_v[0]),
    .sdata_in(sdata_in), .sdata_out(dout[0]), .busy(busy_v[0]), .irq(irq_v[0])
  );

  crc_stream_engine #(
    .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
    .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
  ) u_c32 (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd_v[1]), .swr(swr_v[1]),
    .sdata_in(sdata_in), .sdata_out(dout[1]), .busy(busy_v[1]), .irq(irq_v[1])
  );

  crc_stream_engine #(
    .CRC_W(16), .POLY(32'h00001021), .INIT(32'h0000FFFF)
  ) u_c16 (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd_v[2]), .swr(swr_v[2]),
    .sdata_in(sdata_in), .sdata_out(dout[2]), .busy(busy_v[2]), .irq(irq_v[2])
  );

  crc_stream_engine #(
    .DEPTH(4)
  ) u_d4 (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd_v[3]), .swr(swr_v[3]),
    .sdata_in(sdata_in), .sdata_out(dout[3]), .busy(busy_v[3]), .irq(irq_v[3])
  );

  // Message treated as one long bit stream divided by the generator polynomial.
  function automatic logic [31:0] model(input int u, input logic [7:0] msg [$]);
    int w;
    logic [63:0] poly, crc, xo, mask, r;
    bit rin, rout, din, top;
    w = 32; poly = 64'h814141AB; crc = 64'h0; xo = 64'h0; rin = 1'b0; rout = 1'b0;
    if (u == 1) begin
      poly = 64'h04C11DB7; crc = 64'hFFFFFFFF; xo = 64'hFFFFFFFF; rin = 1'b1; rout = 1'b1;
    end
    if (u == 2) begin
      w = 16; poly = 64'h1021; crc = 64'hFFFF;
    end
    mask = (64'd1 << w) - 64'd1;
    foreach (msg[i]) begin
      for (int b = 0; b < 8; b++) begin
        din = rin ? msg[i][b] : msg[i][7-b];
        top = crc[w-1] ^ din;
        crc = (crc << 1) & mask;
        if (top) crc = crc ^ (poly & mask);
      end
    end
    r = crc;
    if (rout) begin
      r = 64'h0;
      for (int j = 0; j < w; j++) r[w-1-j] = crc[j];
    end
    return 32'((r ^ xo) & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input int u, input logic [16:0] off, input logic [31:0] d);
    saddress = Base + off;
    sdata_in = d;
    swr_v[u] = 1'b1;
    @(posedge clk);
    #1;
    swr_v = '0;
  endtask

  task automatic bus_rd(input int u, input logic [16:0] off, output logic [31:0] d);
    saddress = Base + off;
    srd_v[u] = 1'b1;
    @(posedge clk);
    #1;
    srd_v = '0;
    d = dout[u];
  endtask

  task automatic wait_done(input int u, input string tag);
    logic [31:0] s;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      bus_rd(u, OffStatus, s);
      seen = s[3];
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic run_msg(input int u, input logic [7:0] pre [$], input logic [7:0] dur [$],
                         input logic [31:0] ctrl, input string tag);
    logic [7:0]  all [$];
    logic [31:0] r;
    all = {pre, dur};
    foreach (pre[i]) bus_wr(u, OffData, 32'(pre[i]));
    bus_wr(u, OffCtrl, ctrl);
    foreach (dur[i]) bus_wr(u, OffData, 32'(dur[i]));
    wait_done(u, tag);
    bus_rd(u, OffResult, r);
    chk(tag, r, model(u, all));
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  pre [$];
    logic [7:0]  dur [$];
    logic [7:0]  none [$];
    logic [7:0]  chk9 [$];
    int busy_hi, first_done, u, npre, ndur;

    reset = 1'b1; saddress = '0; sdata_in = '0; srd_v = '0; swr_v = '0;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("rst_sdata_out", dout[0], 32'h0);
    chk("rst_busy_irq", {30'd0, busy_v[0], irq_v[0]}, 32'h0);
    bus_rd(0, OffStatus, r); chk("rst_status", r, 32'h2);
    bus_rd(0, OffCount, r);  chk("rst_count", r, 32'h0);
    bus_rd(0, OffResult, r); chk("rst_result", r, 32'h0);

    // Single byte: latency and busy width.
    bus_wr(0, OffData, 32'h01);
    bus_wr(0, OffCtrl, 32'h1);
    busy_hi = int'(busy_v[0]);
    first_done = 0;
    for (int k = 1; k <= 8; k++) begin
      saddress = Base + OffStatus;
      srd_v[0] = 1'b1;
      @(posedge clk);
      #1;
      srd_v = '0;
      busy_hi += int'(busy_v[0]);
      if (first_done == 0 && dout[0][3]) first_done = k;
    end
    chk("busy_cycles", 32'(busy_hi), 32'd2);
    chk("done_latency", 32'(first_done), 32'd4);
    bus_rd(0, OffResult, r); chk("one_byte_result", r, 32'h814141AB);
    bus_rd(0, OffStatus, r); chk("status_done", r, 32'h0A);
    bus_wr(0, OffCtrl, 32'h8);

    pre = '{8'h00, 8'h00};
    run_msg(0, pre, none, 32'h1, "two_zero");
    bus_rd(0, OffResult, r); chk("two_zero_const", r, 32'h0);
    bus_wr(0, OffCtrl, 32'h8);
    idle(1);
    bus_rd(0, OffStatus, r); chk("ack_status", r, 32'h2);

    chk9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_msg(1, chk9, none, 32'h1, "crc32_model");
    bus_rd(1, OffResult, r); chk("crc32_check", r, 32'hCBF43926);
    bus_wr(1, OffCtrl, 32'h8);
    run_msg(2, chk9, none, 32'h1, "crc16_model");
    bus_rd(2, OffResult, r); chk("crc16_check", r, 32'h000029B1);

    // Shallow FIFO: overflow, then CLEAR wipes everything including RESULT.
    pre = '{8'h01};
    run_msg(3, pre, none, 32'h1, "d4_run");
    bus_rd(3, OffResult, r); chk("d4_result", r, 32'h814141AB);
    bus_wr(3, OffCtrl, 32'h8);
    for (int i = 0; i < 5; i++) bus_wr(3, OffData, 32'(i + 7));
    bus_rd(3, OffCount, r);  chk("d4_count_full", r, 32'd4);
    bus_rd(3, OffStatus, r); chk("d4_status_ovf", r, 32'h11);
    bus_wr(3, OffCtrl, 32'h2);
    idle(1);
    bus_rd(3, OffCount, r);  chk("clr_count", r, 32'd0);
    bus_rd(3, OffStatus, r); chk("clr_status", r, 32'h2);
    bus_rd(3, OffResult, r); chk("clr_result", r, 32'h0);

    // Streaming with irq enabled.
    pre = {}; dur = {};
    for (int i = 0; i < 3; i++) pre.push_back(8'($urandom));
    for (int i = 0; i < 2; i++) dur.push_back(8'($urandom));
    run_msg(0, pre, dur, 32'h5, "stream5");
    chk("irq_high", 32'(irq_v[0]), 32'd1);
    bus_wr(0, OffCtrl, 32'hC);
    idle(1);
    chk("irq_after_ack", 32'(irq_v[0]), 32'd0);
    bus_rd(0, OffStatus, r); chk("irq_en_status", r, 32'h22);

    // Reset mid-RUN.
    for (int i = 0; i < 10; i++) bus_wr(0, OffData, 32'($urandom));
    bus_wr(0, OffCtrl, 32'h1);
    idle(3);
    chk("midrun_busy", 32'(busy_v[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrun_rst_outs", {dout[0][29:0], busy_v[0], irq_v[0]}, 32'h0);
    idle(1);
    reset = 1'b0;
    bus_rd(0, OffCount, r);  chk("midrun_count", r, 32'h0);
    bus_rd(0, OffStatus, r); chk("midrun_status", r, 32'h2);

    // Randomised messages, including an empty one.
    run_msg(1, none, none, 32'h1, "crc32_empty");
    bus_wr(1, OffCtrl, 32'h8);
    for (int it = 0; it < 8; it++) begin
      u = it % 2;
      npre = $urandom_range(12, 1);
      ndur = $urandom_range(4, 0);
      pre = {}; dur = {};
      for (int i = 0; i < npre; i++) pre.push_back(8'($urandom));
      for (int i = 0; i < ndur; i++) dur.push_back(8'($urandom));
      run_msg(u, pre, dur, 32'h1, $sformatf("rand%0d", it));
      bus_wr(u, OffCtrl, 32'h8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
